// File: rtl/group_result_drain_pkg.sv
// Shared sizing helpers for the MAC group family: result width and index width.
// Imported by group_result_drain and its MAC-side neighbours.
package group_result_drain_pkg;

  function automatic int res_width(input int img_w, input int ker_w);
    return img_w + ker_w + 1;
  endfunction

  // ceil(log2(n)), never less than 1 so a single-element group still has an index bit
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/group_result_drain.sv
// Snapshots a MAC group's parallel result bus and serializes it over valid/ready.
// Optional macro GROUP_RESULT_DRAIN_RELU_EN clamps negative results to zero at capture.
module group_result_drain
  import group_result_drain_pkg::*;
#(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  localparam int RES_WIDTH = res_width(IMG_WIDTH, KER_WIDTH),
  localparam int IDX_WIDTH = clog2_min1(GROUP_NB)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GROUP_NB*RES_WIDTH-1:0] result,
  input  logic                          take,
  output logic                          busy,
  output logic                          overflow,
  output logic [RES_WIDTH-1:0]          out_data,
  output logic [IDX_WIDTH-1:0]          out_idx,
  output logic                          out_last,
  output logic                          out_val,
  input  logic                          out_rdy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GROUP_NB - 1);

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [RES_WIDTH-1:0]   snap_q [GROUP_NB];
  logic [RES_WIDTH-1:0]   snap_d [GROUP_NB];
  logic [RES_WIDTH-1:0]   data_q, data_d;
  logic                   last_q, last_d;
  logic                   overflow_q, overflow_d;
  logic                   capture_s;
  logic                   xfer_s;

  function automatic logic [RES_WIDTH-1:0] clamp_elem(input logic [RES_WIDTH-1:0] v);
`ifdef GROUP_RESULT_DRAIN_RELU_EN
    return v[RES_WIDTH-1] ? {RES_WIDTH{1'b0}} : v;
`else
    return v;
`endif
  endfunction

  // Next-state: capture, advance, recapture on last beat, or flag a dropped take
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    capture_s  = 1'b0;
    xfer_s     = (state_q == SEND) && out_rdy;
    case (state_q)
      IDLE: begin
        if (take) begin
          capture_s = 1'b1;
          state_d   = SEND;
          idx_d     = {IDX_WIDTH{1'b0}};
        end else begin
          state_d   = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && (idx_q == LAST_IDX)) begin
          idx_d = {IDX_WIDTH{1'b0}};
          if (take) begin
            capture_s = 1'b1;
            state_d   = SEND;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          if (take) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          if (xfer_s) begin
            idx_d = idx_q + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            idx_d = idx_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_WIDTH{1'b0}};
      end
    endcase
    for (int i = 0; i < GROUP_NB; i++) begin
      snap_d[i] = capture_s ? clamp_elem(result[i*RES_WIDTH +: RES_WIDTH]) : snap_q[i];
    end
    // Output word follows the next index, so it is stable whenever idx holds
    data_d = snap_d[idx_d];
    last_d = (state_d == SEND) && (idx_d == LAST_IDX);
  end

  // State, snapshot and registered stream outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= {IDX_WIDTH{1'b0}};
      data_q     <= {RES_WIDTH{1'b0}};
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < GROUP_NB; i++) begin
        snap_q[i] <= {RES_WIDTH{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < GROUP_NB; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign busy     = (state_q == SEND);
  assign out_val  = (state_q == SEND);
  assign out_idx  = idx_q;
  assign out_last = last_q;
  assign out_data = data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_group_result_drain.sv
// Directed scoreboard bench for group_result_drain (GROUP_NB=4, 33-bit results).
module tb_group_result_drain;

  localparam int NB = 4;
  localparam int W  = 33;

  typedef struct {
    logic [W-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NB*W-1:0]   result = '0;
  logic              take = 1'b0;
  logic              busy;
  logic              overflow;
  logic [W-1:0]      out_data;
  logic [1:0]        out_idx;
  logic              out_last;
  logic              out_val;
  logic              out_rdy = 1'b0;

  beat_t exp_q[$];
  int    total = 0;
  int    passed = 0;

  group_result_drain #(.GROUP_NB(NB), .IMG_WIDTH(16), .KER_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .result(result), .take(take), .busy(busy),
    .overflow(overflow), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_val(out_val), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] v);
`ifdef GROUP_RESULT_DRAIN_RELU_EN
    return v[W-1] ? {W{1'b0}} : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [NB*W-1:0] pack4(input logic [W-1:0] e0, input logic [W-1:0] e1,
                                            input logic [W-1:0] e2, input logic [W-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic push_snap(input logic [NB*W-1:0] bus);
    beat_t b;
    for (int i = 0; i < NB; i++) begin
      b.data = model(bus[i*W +: W]);
      b.idx  = 2'(i);
      b.last = (i == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (out_val && out_rdy && !rst) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {31'd0, out_data}, 64'hDEAD);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", {28'd0, out_data, out_idx, out_last}, {28'd0, e.data, e.idx, e.last});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    out_rdy = 1'b1;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    check({tag, "_drain_done"}, {62'd0, busy, 1'b0}, 64'd0);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_val_low"}, {63'd0, out_val}, 64'd0);
  endtask

  task automatic send_take(input logic [NB*W-1:0] bus);
    result = bus;
    take   = 1'b1;
    push_snap(bus);
    step();
    take   = 1'b0;
  endtask

  initial begin
    logic [NB*W-1:0] bus;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_val", {63'd0, out_val}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_idx", {62'd0, out_idx}, 64'd0);
    check("rst_last", {63'd0, out_last}, 64'd0);
    check("rst_data", {31'd0, out_data}, 64'd0);
    step();
    rst = 1'b0;
    step();

    // Basic: out_val rises one cycle after take
    out_rdy = 1'b1;
    send_take(pack4(33'd1, 33'd2, 33'd3, 33'd4));
    check("basic_val_latency", {63'd0, out_val}, 64'd1);
    check("basic_first_data", {31'd0, out_data}, 64'd1);
    drain("basic");

    // Stall on idx 1
    send_take(pack4(33'd1, 33'd2, 33'd3, 33'd4));
    step();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_data", {31'd0, out_data}, 64'd2);
      check("stall_idx", {62'd0, out_idx}, 64'd1);
      check("stall_last", {63'd0, out_last}, 64'd0);
    end
    drain("stall");

    // Back-to-back: recapture on the cycle the last beat transfers
    send_take(pack4(33'd1, 33'd2, 33'd3, 33'd4));
    n = 0;
    while (!out_last && n < 20) begin
      step();
      n++;
    end
    check("b2b_reached_last", {63'd0, out_last}, 64'd1);
    send_take(pack4(33'd5, 33'd6, 33'd7, 33'd8));
    check("b2b_no_bubble_val", {63'd0, out_val}, 64'd1);
    check("b2b_no_bubble_idx", {62'd0, out_idx}, 64'd0);
    check("b2b_data", {31'd0, out_data}, 64'd5);
    drain("b2b");
    check("b2b_ovf", {63'd0, overflow}, 64'd0);

    // Overflow: take at idx 2 is dropped, old snapshot keeps streaming
    send_take(pack4(33'd1, 33'd2, 33'd3, 33'd4));
    step();
    step();
    check("ovf_at_idx2", {62'd0, out_idx}, 64'd2);
    result = pack4(33'd9, 33'd10, 33'd11, 33'd12);
    take = 1'b1;
    step();
    take = 1'b0;
    check("ovf_set", {63'd0, overflow}, 64'd1);
    drain("ovf");
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset mid-stream between edges at idx 1
    bus = pack4(33'd21, 33'd22, 33'd23, 33'd24);
    result = bus;
    take = 1'b1;
    exp_q.push_back('{data: model(bus[W-1:0]), idx: 2'd0, last: 1'b0});
    step();
    take = 1'b0;
    step();
    check("mid_idx1", {62'd0, out_idx}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_val", {63'd0, out_val}, 64'd0);
    check("mid_rst_ovf", {63'd0, overflow}, 64'd0);
    step();
    rst = 1'b0;
    check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    send_take(pack4(33'd31, 33'd32, 33'd33, 33'd34));
    check("post_rst_idx0", {62'd0, out_idx}, 64'd0);
    drain("post_rst");

    // Negative element: raw, or clamped when RELU is built in
    send_take(pack4(33'd7, 33'h1_FFFF_FFFB, 33'h0_7FFF_FFFF, 33'h1_0000_0000));
    step();
    check("neg_elem1",
          {31'd0, out_data},
`ifdef GROUP_RESULT_DRAIN_RELU_EN
          64'd0
`else
          64'h1_FFFF_FFFB
`endif
    );
    drain("neg");

    // Random data with random backpressure
    for (int s = 0; s < 3; s++) begin
      bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
      out_rdy = 1'b1;
      send_take(bus);
      n = 0;
      while (busy && n < 60) begin
        out_rdy = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      drain("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
